score_bcd_converter: RTL
========================

SCORE_BCD_CONVERTER -- requirements
Module: score_bcd_converter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port `clk`: input, 1 bit, the system clock; all state is updated on its rising edge.
REQ-003 Port `nRst_i`: input, 1 bit, asynchronous active-low reset.
REQ-004 Port `start`: input, 1 bit, conversion request; sampled only in IDLE.
REQ-005 Port `score`: input, 7 bits, unsigned binary score (0-127); sampled on the start edge only.
REQ-006 Port `busy`: output, 1 bit, high whenever state is not IDLE.
REQ-007 Port `done`: output, 1 bit, single-cycle pulse marking a valid result.
REQ-008 Port `hundreds`: output, 1 bit, BCD hundreds digit (0 or 1).
REQ-009 Port `tens`: output, 4 bits, BCD tens digit (0-9).
REQ-010 Port `units`: output, 4 bits, BCD units digit (0-9).

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and DONE, encoded in 2 bits.
REQ-012 IDLE with start=1 at an edge (edge 0) SHALL load score into a working register, zero the BCD working digits, clear the shift counter and go to SHIFT.
REQ-013 In SHIFT, on each edge: any working BCD digit >=5 gets +3 (tens and units, 4-bit), then the {BCD, binary} register shifts left 1.
REQ-014 SHIFT SHALL perform exactly 7 shifts (edges 1-7), tracked by a 3-bit counter.
REQ-015 On edge 7 the FSM SHALL enter DONE, and hundreds/tens/units SHALL register the final digits.
REQ-016 done SHALL equal (state==DONE): high for exactly one cycle, beginning 7 edges after the start edge.
REQ-017 DONE SHALL return to IDLE on the next edge, unconditionally.
REQ-018 Conversion latency start-edge to result SHALL be fixed at 7 cycles, with a throughput of one conversion per 9 cycles.
REQ-019 start asserted in SHIFT or DONE SHALL be ignored: not queued, with no effect on the result in progress.
REQ-020 A score change after the start edge SHALL not affect the result in progress.
REQ-021 hundreds/tens/units SHALL hold their last result until the next DONE entry.
REQ-022 These outputs SHALL never show intermediate SHIFT values.
REQ-023 Every input 0-127 SHALL give a valid BCD result equal to the decimal value; no overflow condition exists.
REQ-024 A level-high start held in IDLE SHALL start back-to-back conversions, one per 9 cycles.

Reset
REQ-025 nRst_i=0 SHALL force, immediately and regardless of clk: state=IDLE, busy=0, done=0, hundreds=0, tens=0, units=0, shift counter=0 and working registers=0.
REQ-026 Reset asserted mid-conversion SHALL abort it.
REQ-027 After reset release, no done SHALL occur until a new start is sampled.

Configuration
REQ-028 Macro SCORE_SSEG_EN, when defined, SHALL add outputs `ss_tens` and `ss_units`, each 8 bits, holding seven-segment patterns.
REQ-029 Segment bit order: bit0=a through bit6=g, bit7=dp, always 0; patterns are active-high.
REQ-030 Digit patterns 0-9 SHALL be 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex).
REQ-031 ss_tens/ss_units SHALL be registered on the same edge as tens/units and reset to 00.
REQ-032 ss_tens SHALL be 00 (blank) when hundreds=0 and tens=0.
REQ-033 Without SCORE_SSEG_EN, ss_tens/ss_units and their logic SHALL be absent, with all other behaviour identical.

Verification
REQ-034 Reset, then start with score=0: done one cycle, 7 cycles later; hundreds=0, tens=0, units=0; with SCORE_SSEG_EN, ss_tens=00 and ss_units=3F.
REQ-035 score=99 start: tens=9, units=9, hundreds=0; with SCORE_SSEG_EN, ss_tens=6F and ss_units=6F.
REQ-036 score=127 start: hundreds=1, tens=2, units=7; busy high for 8 cycles.
REQ-037 score=42 start, then start pulsed with score=5 at cycles 3 and 7 after the start edge: single done, result 4/2; no second done.
REQ-038 score=88 start, nRst_i low at cycle 4: outputs immediately 0, busy=0, no done after release.
REQ-039 start held high with score=7 then 64: done every 9 cycles; results 0/0/7 then 0/6/4; outputs stable between dones.

Source files
------------

// File: rtl/score_bcd_converter_if.sv
// Bundles the request side (start/score) and the result side
// (busy/done/digits) of the score-to-BCD converter.
// Optional macro SCORE_SSEG_EN adds the two seven-segment outputs.
interface score_bcd_converter_if;
  logic       start;
  logic [6:0] score;
  logic       busy;
  logic       done;
  logic       hundreds;
  logic [3:0] tens;
  logic [3:0] units;
`ifdef SCORE_SSEG_EN
  logic [7:0] ss_tens;
  logic [7:0] ss_units;

  modport master (output start, score,
                  input  busy, done, hundreds, tens, units, ss_tens, ss_units);
  modport slave  (input  start, score,
                  output busy, done, hundreds, tens, units, ss_tens, ss_units);
`else
  modport master (output start, score,
                  input  busy, done, hundreds, tens, units);
  modport slave  (input  start, score,
                  output busy, done, hundreds, tens, units);
`endif
endinterface

// File: rtl/score_bcd_converter.sv
// Converts a 7-bit binary score (0-127) to BCD hundreds/tens/units using a
// sequential double-dabble: one add-3/shift step per clock, 7 steps total.
// Result digits are only updated on entry to DONE, so SHIFT intermediates
// never reach the outputs.
// Optional macro SCORE_SSEG_EN adds registered seven-segment outputs
// ss_tens/ss_units (bit0=a .. bit6=g, bit7=dp always 0, active-high).
module score_bcd_converter (
  input  logic                  clk,
  input  logic                  nRst_i,
  score_bcd_converter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_reg;
  logic [2:0]  cnt_reg;
  // {hundreds(1), tens(4), units(4), binary(7)}
  logic [15:0] work_reg;
  logic [15:0] work_next;
  logic [3:0]  tens_adj;
  logic [3:0]  units_adj;
  logic        busy_reg;
  logic        done_reg;
  logic        hundreds_reg;
  logic [3:0]  tens_reg;
  logic [3:0]  units_reg;

  // One double-dabble step: correct digits >=5 by +3, then shift left.
  // Hundreds never exceeds 1, so it needs no correction.
  always_comb begin
    tens_adj  = (work_reg[14:11] >= 4'd5) ? work_reg[14:11] + 4'd3 : work_reg[14:11];
    units_adj = (work_reg[10:7]  >= 4'd5) ? work_reg[10:7]  + 4'd3 : work_reg[10:7];
    work_next = {work_reg[15], tens_adj, units_adj, work_reg[6:0]} << 1;
  end

`ifdef SCORE_SSEG_EN
  logic [7:0] ss_tens_reg;
  logic [7:0] ss_units_reg;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Segment patterns follow the digit registers; tens blanks when the
  // whole number is below 10 (leading-zero suppression).
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      ss_tens_reg  <= 8'h00;
      ss_units_reg <= 8'h00;
    end else if (state_reg == SHIFT && cnt_reg == 3'd6) begin
      ss_tens_reg  <= (!work_next[15] && work_next[14:11] == 4'd0) ? 8'h00 : seg7(work_next[14:11]);
      ss_units_reg <= seg7(work_next[10:7]);
    end
  end

  assign bus.ss_tens  = ss_tens_reg;
  assign bus.ss_units = ss_units_reg;
`endif

  // Control FSM with registered busy/done and result digits.
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      state_reg    <= IDLE;
      cnt_reg      <= 3'd0;
      work_reg     <= 16'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      hundreds_reg <= 1'b0;
      tens_reg     <= 4'd0;
      units_reg    <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            work_reg  <= {9'd0, bus.score};
            cnt_reg   <= 3'd0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          work_reg <= work_next;
          cnt_reg  <= cnt_reg + 3'd1;
          // Seventh shift: capture the final digits and flag completion.
          if (cnt_reg == 3'd6) begin
            hundreds_reg <= work_next[15];
            tens_reg     <= work_next[14:11];
            units_reg    <= work_next[10:7];
            done_reg     <= 1'b1;
            state_reg    <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.hundreds = hundreds_reg;
  assign bus.tens     = tens_reg;
  assign bus.units    = units_reg;

endmodule
